// File: rtl/cfg_fork_dat.sv
// Buffered config-data fork: one wide word in, CHANNELS independent per-field FIFOs out.
// Optional input stall counter enabled by defining CFG_FORK_DAT_STALL_CNT_EN.
module cfg_fork_dat #(
  parameter int FIELD_WIDTH = 32,
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CHANNELS-1:0]             cfg_en,
  input  logic [CHANNELS*FIELD_WIDTH-1:0] t_0_dat,
  input  logic                            t_0_req,
  output logic                            t_0_ack,
  output logic [CHANNELS*FIELD_WIDTH-1:0] i_dat,
  output logic [CHANNELS-1:0]             i_req,
  input  logic [CHANNELS-1:0]             i_ack,
  output logic [15:0]                     stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CHANNELS-1:0] w_full;
  logic                w_push;

  // Ack depends only on registered occupancy and enables, never on i_ack.
  assign t_0_ack = &(~cfg_en | ~w_full);
  assign w_push  = t_0_req & t_0_ack;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [FIELD_WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]          r_wr_ptr;
      logic [AW-1:0]          r_rd_ptr;
      logic [AW:0]            r_count;
      logic [FIELD_WIDTH-1:0] w_field;
      logic                   w_ch_push;
      logic                   w_ch_pop;

      // Channel 0 owns the most-significant field.
      assign w_field   = t_0_dat[(CHANNELS-gi)*FIELD_WIDTH-1 -: FIELD_WIDTH];
      assign w_ch_push = w_push & cfg_en[gi];
      assign w_ch_pop  = i_req[gi] & i_ack[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_ch_push) begin
            r_mem[r_wr_ptr] <= w_field;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
          end
          if (w_ch_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          case ({w_ch_push, w_ch_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end

      assign w_full[gi] = (r_count == FULL_CNT);
      assign i_req[gi]  = (r_count != '0);
      assign i_dat[(CHANNELS-gi)*FIELD_WIDTH-1 -: FIELD_WIDTH] = r_mem[r_rd_ptr];
    end
  endgenerate

`ifdef CFG_FORK_DAT_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (t_0_req && !t_0_ack && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cfg_fork_dat.sv
// Self-checking bench for cfg_fork_dat: per-channel queue model, directed and random phases.
module tb_cfg_fork_dat;
  localparam int FW = 32;
  localparam int CH = 4;
  localparam int DP = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CH-1:0]    cfg_en;
  logic [CH*FW-1:0] t_0_dat;
  logic             t_0_req;
  logic             t_0_ack;
  logic [CH*FW-1:0] i_dat;
  logic [CH-1:0]    i_req;
  logic [CH-1:0]    i_ack;
  logic [15:0]      stall_cnt;

  cfg_fork_dat #(.FIELD_WIDTH(FW), .CHANNELS(CH), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_en(cfg_en), .t_0_dat(t_0_dat),
    .t_0_req(t_0_req), .t_0_ack(t_0_ack), .i_dat(i_dat), .i_req(i_req),
    .i_ack(i_ack), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one circular list of expected words per channel.
  logic [FW-1:0] m_q [CH][256];
  int            m_hd [CH];
  int            m_tl [CH];
  int            m_stall;
  logic          accepted;
  int            total = 0;
  int            bad   = 0;

  function automatic int m_size(int k);
    return m_tl[k] - m_hd[k];
  endfunction

  function automatic logic m_ack();
    logic a = 1'b1;
    for (int k = 0; k < CH; k++)
      if (cfg_en[k] && m_size(k) >= DP) a = 1'b0;
    return a;
  endfunction

  function automatic logic [15:0] m_stall_exp();
`ifdef CFG_FORK_DAT_STALL_CNT_EN
    return 16'(m_stall);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < CH; k++) begin
      m_hd[k] = 0;
      m_tl[k] = 0;
    end
    m_stall = 0;
  endtask

  task automatic check_outputs();
    chk("t_0_ack", 32'(t_0_ack), 32'(m_ack()));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_exp()));
    for (int k = 0; k < CH; k++) begin
      chk($sformatf("i_req[%0d]", k), 32'(i_req[k]), 32'(m_size(k) != 0));
      if (m_size(k) != 0)
        chk($sformatf("i_dat[%0d]", k), i_dat[(CH-1-k)*FW +: FW], m_q[k][m_hd[k] % 256]);
    end
  endtask

  // Called at the active edge, before any input changes; pops use pre-edge occupancy.
  task automatic model_edge();
    logic a;
    a = m_ack();
    accepted = t_0_req && a;
    if (t_0_req && !a && m_stall < 16'hFFFF) m_stall++;
    for (int k = 0; k < CH; k++)
      if (m_size(k) != 0 && i_ack[k]) m_hd[k]++;
    if (accepted)
      for (int k = 0; k < CH; k++)
        if (cfg_en[k]) begin
          m_q[k][m_tl[k] % 256] = t_0_dat[(CH-1-k)*FW +: FW];
          m_tl[k]++;
        end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [CH*FW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int sent;
  int cyc;

  initial begin
    reset_n = 1'b0; cfg_en = 4'hF; t_0_req = 1'b0; t_0_dat = '0; i_ack = 4'hF;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_i_dat", i_dat[31:0] | i_dat[63:32] | i_dat[95:64] | i_dat[127:96], 32'h0);
    chk("reset_i_req", 32'(i_req), 32'h0);
    chk("reset_ack", 32'(t_0_ack), 32'h1);
    chk("reset_stall", 32'(stall_cnt), 32'h0);
    reset_n = 1'b1;

    // Streaming: 8 patterned words, all consumers ready.
    sent = 0;
    for (cyc = 0; cyc < 40 && sent < 8; cyc++) begin
      t_0_req = 1'b1;
      t_0_dat = {32'(sent*256+1), 32'(sent*256+2), 32'(sent*256+3), 32'(sent*256+4)};
      step();
      if (accepted) sent++;
    end
    chk("stream_sent", 32'(sent), 32'd8);
    t_0_req = 1'b0;
    repeat (3) step();

    // Backpressure: channel 2 stalled until well after the FIFO fills.
    i_ack = 4'b1011;
    sent = 0;
    for (cyc = 0; cyc < 60 && sent < 6; cyc++) begin
      if (cyc == 10) i_ack = 4'hF;
      t_0_req = 1'b1;
      t_0_dat = rnd_word();
      step();
      if (accepted) sent++;
    end
    chk("bp_sent", 32'(sent), 32'd6);
    t_0_req = 1'b0;
    repeat (4) step();

    // Skewed drain rates.
    sent = 0;
    for (cyc = 0; cyc < 300 && sent < 20; cyc++) begin
      i_ack = {1'b1, 1'b1, 1'(cyc % 3 == 0), 1'(cyc % 2)};
      t_0_req = 1'b1;
      t_0_dat = rnd_word();
      step();
      if (accepted) sent++;
    end
    chk("skew_sent", 32'(sent), 32'd20);
    t_0_req = 1'b0;
    i_ack = 4'hF;
    repeat (8) step();

    // Channel disable: fill channel 2, then drop it from cfg_en while traffic continues.
    i_ack = 4'b1011;
    for (cyc = 0; cyc < 8; cyc++) begin
      t_0_req = 1'b1;
      t_0_dat = rnd_word();
      step();
    end
    cfg_en = 4'b1011;
    i_ack  = 4'hF;
    for (cyc = 0; cyc < 12; cyc++) begin
      t_0_dat = rnd_word();
      step();
    end
    t_0_req = 1'b0;
    cfg_en = 4'hF;
    step();

    // Reset mid-transfer with 3 words buffered per channel.
    i_ack = 4'h0;
    for (cyc = 0; cyc < 3; cyc++) begin
      t_0_req = 1'b1;
      t_0_dat = rnd_word();
      step();
    end
    t_0_req = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_i_req", 32'(i_req), 32'h0);
    chk("midrst_ack", 32'(t_0_ack), 32'h1);
    model_clear();
    i_ack = 4'hF;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();

    // Randomized traffic.
    for (cyc = 0; cyc < 300; cyc++) begin
      cfg_en  = 4'($urandom_range(0, 15));
      i_ack   = 4'($urandom_range(0, 15));
      t_0_req = 1'($urandom_range(0, 1));
      t_0_dat = rnd_word();
      step();
    end
    t_0_req = 1'b0;
    cfg_en = 4'hF;
    i_ack = 4'hF;
    repeat (6) step();

`ifdef CFG_FORK_DAT_STALL_CNT_EN
    // Saturation: channel 0 full, request held for 70000 cycles.
    cfg_en = 4'b0001;
    i_ack  = 4'h0;
    t_0_req = 1'b1;
    for (cyc = 0; cyc < 70000; cyc++) begin
      t_0_dat = rnd_word();
      @(posedge clk);
      model_edge();
      #1;
    end
    step();
    chk("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
    t_0_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
